interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt/reset sequencer for a 6502-style core. It fetches the reset vector
// after reset, and on an accepted NMI/IRQ/BRK it pushes PCH, PCL and P onto the
// stack page and then fetches the selected vector. All outputs are registered.
module interrupt_sequencer #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          NUM_IRQ     = 1,
  parameter logic [15:0] VECTOR_BASE = 16'hFFFA,
  parameter logic [7:0]  STACK_PAGE  = 8'h01
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  nmi_n,
  input  logic [NUM_IRQ-1:0]    irq_n,
  input  logic                  start,
  input  logic                  brk,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [7:0]            p_in,
  input  logic [7:0]            s_in,
  input  logic [7:0]            rd_data,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            wr_data,
  output logic                  wr_enable,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [7:0]            s_out,
  output logic                  set_i,
  output logic [2:0]            irq_id
);

  typedef enum logic [3:0] {
    RST_VL, RST_VH, IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, DONE
  } state_t;

  localparam logic [15:0] NMI_VEC = VECTOR_BASE;
  localparam logic [15:0] RST_VEC = VECTOR_BASE + 16'd2;
  localparam logic [15:0] IRQ_VEC = VECTOR_BASE + 16'd4;

  state_t r_state, w_stateNxt;

  logic        r_nmiHist, r_nmiPending, w_nmiFall;
  logic        w_irqOk, w_accept;
  logic [2:0]  w_irqSel;

  logic [7:0]  r_pcHi, r_pcLo, r_p, r_s;
  logic        r_bFlag, r_isNmi;
  logic [15:0] r_vec;
  logic [7:0]  w_sM1, w_sM2, w_sM3;

  logic [ADDR_WIDTH-1:0] r_address, w_addressNxt;
  logic [7:0]            r_wrData, w_wrDataNxt;
  logic                  r_wrEnable, w_wrEnableNxt;
  logic                  r_busy, w_busyNxt;
  logic                  r_done, w_doneNxt;
  logic                  r_setI, w_setINxt;
  logic [ADDR_WIDTH-1:0] r_pcOut, w_pcOutNxt;
  logic [7:0]            r_sOut, w_sOutNxt;
  logic [2:0]            r_irqId, w_irqIdNxt;

  assign w_nmiFall = r_nmiHist & ~nmi_n;
  assign w_irqOk   = (~&irq_n) & ~p_in[2];
  assign w_accept  = (r_state == IDLE) & start & (r_nmiPending | brk | w_irqOk);
  assign w_sM1     = r_s - 8'd1;
  assign w_sM2     = r_s - 8'd2;
  assign w_sM3     = r_s - 8'd3;

  // Lowest-numbered asserted IRQ channel wins.
  always_comb begin
    w_irqSel = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (!irq_n[i]) w_irqSel = 3'(i);
    end
  end

  // NMI falling-edge detector; a fresh edge beats the clear at the end of the push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_nmiHist    <= 1'b1;
      r_nmiPending <= 1'b0;
    end else begin
      r_nmiHist <= nmi_n;
      if (w_nmiFall)
        r_nmiPending <= 1'b1;
      else if (r_state == PUSH_P && r_isNmi)
        r_nmiPending <= 1'b0;
    end
  end

  // Freeze the core context and the chosen request so later input changes cannot disturb the service.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pcHi  <= 8'h00;
      r_pcLo  <= 8'h00;
      r_p     <= 8'h00;
      r_s     <= 8'h00;
      r_bFlag <= 1'b0;
      r_isNmi <= 1'b0;
      r_vec   <= IRQ_VEC;
    end else if (w_accept) begin
      r_pcHi  <= pc_in[15:8];
      r_pcLo  <= pc_in[7:0];
      r_p     <= p_in;
      r_s     <= s_in;
      r_isNmi <= r_nmiPending;
      r_bFlag <= r_nmiPending ? brk : ~w_irqOk;
      r_vec   <= r_nmiPending ? NMI_VEC : IRQ_VEC;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= RST_VL;
    else         r_state <= w_stateNxt;
  end

  // Next-state logic: a fixed walk through the sequence once started.
  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      RST_VL:  w_stateNxt = RST_VH;
      RST_VH:  w_stateNxt = DONE;
      IDLE:    if (w_accept) w_stateNxt = PUSH_H;
      PUSH_H:  w_stateNxt = PUSH_L;
      PUSH_L:  w_stateNxt = PUSH_P;
      PUSH_P:  w_stateNxt = VEC_L;
      VEC_L:   w_stateNxt = VEC_H;
      VEC_H:   w_stateNxt = DONE;
      DONE:    w_stateNxt = IDLE;
      default: w_stateNxt = IDLE;
    endcase
  end

  // Output logic: values the bus and status outputs take after the transition out of the current state.
  always_comb begin
    w_addressNxt  = r_address;
    w_wrDataNxt   = r_wrData;
    w_wrEnableNxt = 1'b0;
    w_busyNxt     = r_busy;
    w_doneNxt     = 1'b0;
    w_setINxt     = 1'b0;
    w_pcOutNxt    = r_pcOut;
    w_sOutNxt     = r_sOut;
    w_irqIdNxt    = r_irqId;
    case (r_state)
      RST_VL: begin
        w_pcOutNxt[7:0] = rd_data;
        w_addressNxt    = ADDR_WIDTH'(RST_VEC + 16'd1);
      end
      RST_VH: begin
        w_pcOutNxt[15:8] = rd_data;
        w_sOutNxt        = 8'hFD;
      end
      IDLE: begin
        if (w_accept) begin
          w_addressNxt  = ADDR_WIDTH'({STACK_PAGE, s_in});
          w_wrDataNxt   = pc_in[15:8];
          w_wrEnableNxt = 1'b1;
          w_busyNxt     = 1'b1;
          w_irqIdNxt    = (!r_nmiPending && w_irqOk) ? w_irqSel : 3'd0;
        end
      end
      PUSH_H: begin
        w_addressNxt  = ADDR_WIDTH'({STACK_PAGE, w_sM1});
        w_wrDataNxt   = r_pcLo;
        w_wrEnableNxt = 1'b1;
      end
      PUSH_L: begin
        w_addressNxt  = ADDR_WIDTH'({STACK_PAGE, w_sM2});
        w_wrDataNxt   = {r_p[7:6], 1'b1, r_bFlag, r_p[3:0]};
        w_wrEnableNxt = 1'b1;
      end
      PUSH_P: begin
        w_addressNxt = ADDR_WIDTH'(r_vec);
      end
      VEC_L: begin
        w_pcOutNxt[7:0] = rd_data;
        w_addressNxt    = ADDR_WIDTH'(r_vec + 16'd1);
      end
      VEC_H: begin
        w_pcOutNxt[15:8] = rd_data;
        w_sOutNxt        = w_sM3;
      end
      DONE: begin
        w_doneNxt = 1'b1;
        w_setINxt = 1'b1;
        w_busyNxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers; reset points the bus at the reset vector low byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_address  <= ADDR_WIDTH'(RST_VEC);
      r_wrData   <= 8'h00;
      r_wrEnable <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_setI     <= 1'b0;
      r_pcOut    <= '0;
      r_sOut     <= 8'h00;
      r_irqId    <= 3'd0;
    end else begin
      r_address  <= w_addressNxt;
      r_wrData   <= w_wrDataNxt;
      r_wrEnable <= w_wrEnableNxt;
      r_busy     <= w_busyNxt;
      r_done     <= w_doneNxt;
      r_setI     <= w_setINxt;
      r_pcOut    <= w_pcOutNxt;
      r_sOut     <= w_sOutNxt;
      r_irqId    <= w_irqIdNxt;
    end
  end

  assign address   = r_address;
  assign wr_data   = r_wrData;
  assign wr_enable = r_wrEnable;
  assign busy      = r_busy;
  assign done      = r_done;
  assign set_i     = r_setI;
  assign pc_out    = r_pcOut;
  assign s_out     = r_sOut;
  assign irq_id    = r_irqId;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios followed by randomized
// requests, all checked against a request-level model of the sequencer.
module tb_interrupt_sequencer;

  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          nmi_n = 1'b1;
  logic [NI-1:0] irq_n = '1;
  logic          start = 1'b0;
  logic          brk = 1'b0;
  logic [15:0]   pc_in = 16'h0000;
  logic [7:0]    p_in = 8'h00;
  logic [7:0]    s_in = 8'h00;
  logic [7:0]    rd_data;
  logic [15:0]   address;
  logic [7:0]    wr_data;
  logic          wr_enable, busy, done, set_i;
  logic [15:0]   pc_out;
  logic [7:0]    s_out;
  logic [2:0]    irq_id;

  logic [7:0]    mem [0:65535];
  logic [23:0]   wrLog [$];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bit          modelNmi = 1'b0;
  logic [2:0]  modelId  = 3'd0;
  logic [15:0] modelPc  = 16'h0000;
  logic [7:0]  modelS   = 8'h00;

  interrupt_sequencer #(
    .ADDR_WIDTH (16),
    .NUM_IRQ    (NI),
    .VECTOR_BASE(16'hFFFA),
    .STACK_PAGE (8'h01)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .start    (start),
    .brk      (brk),
    .pc_in    (pc_in),
    .p_in     (p_in),
    .s_in     (s_in),
    .rd_data  (rd_data),
    .address  (address),
    .wr_data  (wr_data),
    .wr_enable(wr_enable),
    .busy     (busy),
    .done     (done),
    .pc_out   (pc_out),
    .s_out    (s_out),
    .set_i    (set_i),
    .irq_id   (irq_id)
  );

  always #5 clk = ~clk;

  // Memory answers combinationally; the sequencer samples it on the following edge.
  assign rd_data = mem[address];

  // Record every bus write mid-cycle.
  always @(negedge clk) begin
    if (wr_enable === 1'b1) wrLog.push_back({address, wr_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nmiEdge();
    nmi_n = 1'b0;
    @(posedge clk); #1;
    nmi_n = 1'b1;
    @(posedge clk); #1;
    modelNmi = 1'b1;
  endtask

  // Release reset and expect the reset-vector fetch with no stack traffic.
  task automatic releaseReset(input string tag);
    int doneAt;
    logic [15:0] expPc;
    expPc = {mem[16'hFFFD], mem[16'hFFFC]};
    wrLog.delete();
    doneAt = 0;
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && doneAt == 0) doneAt = k;
    end
    checkOutput({tag, ".doneAt"}, doneAt, 3);
    checkOutput({tag, ".pc_out"}, pc_out, expPc);
    checkOutput({tag, ".s_out"}, s_out, 8'hFD);
    checkOutput({tag, ".writes"}, wrLog.size(), 0);
    checkOutput({tag, ".busy"}, busy, 1'b0);
    checkOutput({tag, ".irq_id"}, irq_id, 3'd0);
    modelNmi = 1'b0;
    modelId  = 3'd0;
    modelPc  = expPc;
    modelS   = 8'hFD;
  endtask

  // One instruction-boundary strobe, compared with what the request rules predict.
  task automatic applyStimulus(input string tag, input logic [15:0] pc, input logic [7:0] p,
                               input logic [7:0] s, input logic [NI-1:0] irqs,
                               input bit b, input bit disturb);
    bit acc, bFlag, nmiSvc, nmiPulsed, sawSetI;
    logic [15:0] vec, expPc;
    logic [2:0]  id;
    logic [7:0]  pushedP, sv;
    logic [23:0] expW [3];
    logic [31:0] obsW;
    int doneAt, doneCnt;

    acc = 1'b1; bFlag = 1'b0; id = 3'd0; nmiSvc = modelNmi; vec = 16'hFFFE;
    if (modelNmi) begin
      vec = 16'hFFFA; bFlag = b;
    end else if (irqs != '1 && !p[2]) begin
      for (int i = NI - 1; i >= 0; i--) if (!irqs[i]) id = 3'(i);
    end else if (b) begin
      bFlag = 1'b1;
    end else begin
      acc = 1'b0;
    end
    expPc   = {mem[vec + 16'd1], mem[vec]};
    pushedP = (p & 8'hEF) | 8'h20 | (bFlag ? 8'h10 : 8'h00);
    sv = s;          expW[0] = {8'h01, sv, pc[15:8]};
    sv = s - 8'd1;   expW[1] = {8'h01, sv, pc[7:0]};
    sv = s - 8'd2;   expW[2] = {8'h01, sv, pushedP};

    wrLog.delete();
    pc_in = pc; p_in = p; s_in = s; irq_n = irqs; brk = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; brk = 1'b0;
    pc_in = 16'($urandom); p_in = 8'($urandom); s_in = 8'($urandom);
    checkOutput({tag, ".busyAtAccept"}, busy, acc);

    doneAt = 0; doneCnt = 0; sawSetI = 1'b0; nmiPulsed = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        doneCnt++;
        if (doneAt == 0) begin doneAt = k; sawSetI = set_i; end
      end
      if (disturb && acc) begin
        if (k == 1) begin
          start = 1'b1;
          irq_n = NI'($urandom);
          if (!nmiSvc && nmi_n === 1'b1) begin nmi_n = 1'b0; nmiPulsed = 1'b1; end
        end else if (k == 2) begin
          start = 1'b0;
          if (nmiPulsed) nmi_n = 1'b1;
        end
      end
    end

    checkOutput({tag, ".doneAt"}, doneAt, acc ? 6 : 0);
    checkOutput({tag, ".doneCnt"}, doneCnt, acc ? 1 : 0);
    if (acc) checkOutput({tag, ".set_i"}, sawSetI, 1'b1);
    checkOutput({tag, ".busyEnd"}, busy, 1'b0);
    checkOutput({tag, ".nWrites"}, wrLog.size(), acc ? 3 : 0);
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        obsW = (i < wrLog.size()) ? {8'h00, wrLog[i]} : 32'hxxxxxxxx;
        checkOutput($sformatf("%s.write%0d", tag, i), obsW, {8'h00, expW[i]});
      end
      modelPc = expPc;
      modelS  = s - 8'd3;
      modelId = id;
      if (nmiSvc) modelNmi = 1'b0;
    end
    if (nmiPulsed) modelNmi = 1'b1;
    checkOutput({tag, ".pc_out"}, pc_out, modelPc);
    checkOutput({tag, ".s_out"}, s_out, modelS);
    checkOutput({tag, ".irq_id"}, irq_id, modelId);
  endtask

  initial begin
    logic [NI-1:0] irqs;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h11; mem[16'hFFFB] = 8'hAA;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h56;

    // Reset state.
    #2 resetn = 1'b0;
    #2;
    checkOutput("rst.address", address, 16'hFFFC);
    checkOutput("rst.busy", busy, 1'b1);
    checkOutput("rst.wr_enable", wr_enable, 1'b0);
    checkOutput("rst.wr_data", wr_data, 8'h00);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.pc_out", pc_out, 16'h0000);
    checkOutput("rst.s_out", s_out, 8'h00);
    @(posedge clk); #1;
    releaseReset("boot");

    // Unmasked IRQ on all channels.
    applyStimulus("irq", 16'hC005, 8'h20, 8'hFF, 4'b0000, 1'b0, 1'b0);
    // Masked IRQ, no BRK: nothing happens.
    applyStimulus("masked", 16'h1234, 8'h24, 8'h80, 4'b0000, 1'b0, 1'b0);
    // BRK hijacked by pending NMI, then the pending flag is gone.
    nmiEdge();
    applyStimulus("nmiBrk", 16'hBEEF, 8'h04, 8'h40, 4'b1111, 1'b1, 1'b0);
    applyStimulus("nmiCleared", 16'h0000, 8'h04, 8'h40, 4'b1111, 1'b0, 1'b0);
    // Channel select and stack wrap.
    applyStimulus("chan2", 16'h8001, 8'h00, 8'h01, 4'b0011, 1'b0, 1'b0);
    // Plain BRK.
    applyStimulus("brk", 16'h4321, 8'hC3, 8'h10, 4'b1111, 1'b1, 1'b1);

    // NMI held low arms only once.
    nmi_n = 1'b0;
    @(posedge clk); #1;
    modelNmi = 1'b1;
    applyStimulus("nmiHeld", 16'h2222, 8'h00, 8'hF0, 4'b1111, 1'b0, 1'b0);
    applyStimulus("nmiHeldAgain", 16'h3333, 8'h00, 8'hF0, 4'b1111, 1'b0, 1'b0);
    nmi_n = 1'b1;
    @(posedge clk); #1;
    nmiEdge();
    applyStimulus("nmiRearm", 16'h4444, 8'h00, 8'h02, 4'b1111, 1'b0, 1'b0);

    // Reset in the middle of a push.
    pc_in = 16'h9ABC; p_in = 8'h00; s_in = 8'h50; irq_n = 4'b1110; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checkOutput("abort.wr_enable", wr_enable, 1'b0);
    checkOutput("abort.busy", busy, 1'b1);
    checkOutput("abort.address", address, 16'hFFFC);
    wrLog.delete();
    irq_n = '1;
    @(posedge clk); #1;
    checkOutput("abort.noWrites", wrLog.size(), 0);
    mem[16'hFFFC] = 8'h9D; mem[16'hFFFD] = 8'hE0;
    releaseReset("abortBoot");

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) nmiEdge();
      irqs = ($urandom_range(0, 1) == 1) ? NI'($urandom) : '1;
      applyStimulus($sformatf("rnd%0d", t), 16'($urandom), 8'($urandom), 8'($urandom),
                    irqs, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
